vec_capture_ser2par: RTL
========================

VEC_CAPTURE_SER2PAR -- requirements
Module: vec_capture_ser2par

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning number of captured bits per output word (legal range 2..64).
REQ-002 SHALL have parameter MSB_FIRST, default 0, meaning 0 = first captured bit lands in o_a[0], 1 = first captured bit lands in o_a[WIDTH-1].
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_en, input, 1 bit: capture strobe; samples i_a this cycle.
REQ-006 SHALL have port i_a, input, 1 bit: serial data bit.
REQ-007 SHALL have port i_clr, input, 1 bit: synchronous abort; discards the partial word.
REQ-008 SHALL have port i_ready, input, 1 bit: consumer accepts the presented word.
REQ-009 SHALL have port o_a, output, WIDTH bits: last completed word (registered).
REQ-010 SHALL have port o_valid, output, 1 bit: o_a holds an unaccepted complete word.
REQ-011 SHALL have port o_ovf, output, 1 bit: sticky overrun flag.
REQ-012 SHALL have port o_cnt, output, clog2(WIDTH+1) bits: bits held in the partial word.

Function
REQ-013 SHALL implement a two-state FSM: FILL (accumulating) and FULL (word presented, o_valid=1).
REQ-014 In FILL with i_en=1, SHALL write i_a into the shadow register at index cnt (MSB_FIRST=0) or WIDTH-1-cnt (MSB_FIRST=1), and increment cnt.
REQ-015 When i_en=1 and cnt=WIDTH-1, SHALL copy the completed shadow word into o_a next cycle, wrap cnt to 0, assert o_valid, and go to FULL; latency is 1 cycle from the last strobe to o_valid.
REQ-016 In FULL, SHALL continue filling a new partial word from cnt=0 with i_en, which gives one word of buffering.
REQ-017 In FULL, o_valid&&i_ready SHALL deassert o_valid next cycle and return to FILL, unless a new word completes in the same cycle. In that case o_a is updated to the new word and o_valid stays 1.
REQ-018 SHALL stall on overrun: if the second word completes while FULL and i_ready=0, the completing bit is dropped, cnt holds at WIDTH-1, o_a is unchanged, and o_ovf is set.
REQ-019 o_ovf SHALL remain set until i_rst or i_clr.
REQ-020 i_clr SHALL zero cnt and the shadow register and clear o_ovf, but SHALL NOT change o_a or o_valid; i_clr takes priority over a simultaneous i_en.
REQ-021 o_a SHALL change only on word completion and never expose partial data.
REQ-022 With i_en=0, all state SHALL hold, including in FULL.
REQ-023 o_cnt SHALL equal the registered cnt.

Reset
REQ-024 On i_rst=1, asynchronously: state=FILL, cnt=0, shadow=0, o_a=0, o_valid=0, o_ovf=0, o_cnt=0.
REQ-025 SHALL discard any partial word and any presented word when reset is asserted mid-operation; the first word after deassertion starts at cnt=0.

Structure
REQ-026 The FSM state enum (FILL, FULL) and a cnt-width helper function SHALL live in the shared package vec_capture_pkg.
REQ-027 SHALL have one sub-module, vec_capture_slot, holding the WIDTH-bit shadow register with indexed bit-write and clear; the FSM, counter and output register stay in the top.
REQ-028 SHALL contain no latches: every storage element is an edge-triggered flop with async reset.

Verification
REQ-029 WIDTH=4, MSB_FIRST=0, i_ready=1, i_en=1 for 4 cycles with i_a=1,0,1,1 -> o_a=4'b1101, o_valid high for 1 cycle after the 4th strobe.
REQ-030 Same bit sequence with MSB_FIRST=1 -> o_a=4'b1011.
REQ-031 WIDTH=4, i_ready=0, 9 strobes -> first word is presented, second word is held in shadow with cnt=3, o_ovf=1 after the 8th strobe, and o_a equals the first word.
REQ-032 o_valid=1 and i_ready=1 in the same cycle as a word completes -> o_a takes the new word, o_valid stays 1, o_ovf=0.
REQ-033 2 strobes, then i_clr together with i_en -> o_cnt=0 and o_a unchanged; the next 4 strobes form a complete word.
REQ-034 i_rst pulsed asynchronously between clock edges with cnt=2 and o_valid=1 -> all outputs are 0 immediately, and the next word needs 4 strobes.

Source files
------------

// File: rtl/vec_capture_pkg.sv
// Shared definitions for the serial-to-parallel capture block.
//   state_t   : FSM states (FILL = accumulating, FULL = word presented)
//   cnt_width : width of a counter able to hold the values 0..width
package vec_capture_pkg;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/vec_capture_slot.sv
// Shadow register for the word currently being assembled.
// Ports:
//   i_clk, i_rst : clock and asynchronous active-high reset
//   i_clr        : synchronous clear of the whole shadow word
//   i_wr, i_idx  : write i_bit into bit i_idx on this edge
//   i_bit        : bit value to write
//   o_word       : registered shadow contents
//   o_merged     : shadow contents with the pending i_idx/i_bit applied,
//                  used by the parent to capture a word on its final bit
module vec_capture_slot
    import vec_capture_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_clr,
    input  logic                     i_wr,
    input  logic [$clog2(WIDTH)-1:0] i_idx,
    input  logic                     i_bit,
    output logic [WIDTH-1:0]         o_word,
    output logic [WIDTH-1:0]         o_merged
);

    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] shadow_reg;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic hit;
        assign hit = (i_idx == IW'(gi));

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                shadow_reg[gi] <= 1'b0;
            end else if (i_clr) begin
                shadow_reg[gi] <= 1'b0;
            end else if (i_wr && hit) begin
                shadow_reg[gi] <= i_bit;
            end
        end

        assign o_merged[gi] = hit ? i_bit : shadow_reg[gi];
    end

    assign o_word = shadow_reg;

endmodule

// File: rtl/vec_capture_ser2par.sv
// Serial-to-parallel capture with one word of buffering.
// Bits strobed by i_en are assembled in a shadow slot; a completed word is
// registered on o_a with o_valid until the consumer takes it (i_ready).
// While a word is presented the next one keeps filling; if it completes
// before the first is accepted, its last bit is dropped and o_ovf sticks.
// Ports:
//   i_clk, i_rst : clock and asynchronous active-high reset
//   i_en, i_a    : capture strobe and serial data bit
//   i_clr        : synchronous abort of the partial word, clears o_ovf
//   i_ready      : consumer accepts the presented word
//   o_a, o_valid : last completed word and its valid flag
//   o_ovf        : sticky overrun flag
//   o_cnt        : number of bits in the partial word
module vec_capture_ser2par
    import vec_capture_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_en,
    input  logic                        i_a,
    input  logic                        i_clr,
    input  logic                        i_ready,
    output logic [WIDTH-1:0]            o_a,
    output logic                        o_valid,
    output logic                        o_ovf,
    output logic [cnt_width(WIDTH)-1:0] o_cnt
);

    localparam int CW = cnt_width(WIDTH);
    localparam int IW = $clog2(WIDTH);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH-1:0] word_reg, word_next;
    logic             ovf_reg, ovf_next;

    logic             wr;
    logic             last;
    logic             accept;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] shadow_word;
    logic [WIDTH-1:0] merged_word;

    assign last   = (cnt_reg == CW'(WIDTH - 1));
    assign accept = (state_reg == ST_FULL) && i_ready;
    assign idx    = (MSB_FIRST != 0) ? (IW'(WIDTH - 1) - cnt_reg[IW-1:0])
                                     : cnt_reg[IW-1:0];

    vec_capture_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (i_clr),
        .i_wr     (wr),
        .i_idx    (idx),
        .i_bit    (i_a),
        .o_word   (shadow_word),
        .o_merged (merged_word)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= ST_FILL;
            cnt_reg   <= '0;
            word_reg  <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            word_reg  <= word_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        word_next  = word_reg;
        ovf_next   = ovf_reg;
        wr         = 1'b0;

        // The handshake is independent of capture activity.
        if (accept) begin
            state_next = ST_FILL;
        end

        if (i_clr) begin
            cnt_next = '0;
            ovf_next = 1'b0;
        end else if (i_en) begin
            if (!last) begin
                wr       = 1'b1;
                cnt_next = cnt_reg + CW'(1);
            end else if ((state_reg == ST_FULL) && !i_ready) begin
                // No room for a second word: drop the completing bit, stall.
                ovf_next = 1'b1;
            end else begin
                // Final bit goes straight into the output word; the shadow
                // slot is reused from index 0 by the next word.
                word_next  = merged_word;
                cnt_next   = '0;
                state_next = ST_FULL;
            end
        end
    end

    assign o_a     = word_reg;
    assign o_valid = (state_reg == ST_FULL);
    assign o_ovf   = ovf_reg;
    assign o_cnt   = cnt_reg;

endmodule
